// File: rtl/sl_ifetch_pkg.sv
// Shared types and address helpers for the sequential instruction prefetcher.
// Addresses are word addresses: byte address bits [31:2].
package sl_ifetch_pkg;

    typedef enum logic [1:0] {IDLE, FWD, PF} ifpf_state_t;

    typedef logic [29:0] waddr_t;

    // Word arithmetic wraps mod 2^30, i.e. byte addresses wrap mod 2^32.
    function automatic waddr_t next_word(input waddr_t addr);
        return addr + 30'd1;
    endfunction

    // True when addr is the last word of its 2^page_bits-byte page.
    function automatic logic page_end(input waddr_t addr, input int page_bits);
        waddr_t mask;
        mask = (30'd1 << (page_bits - 2)) - 30'd1;
        return (addr & mask) == mask;
    endfunction

endpackage

// File: rtl/sl_sat_cnt.sv
// Saturating up-counter used for the prefetcher hit/miss statistics.
module sl_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/sl_ifetch_prefetch.sv
// Single-entry next-word prefetcher between the core fetch port and the l1i.
// Hits are served from the buffer in the request cycle; everything else goes to l1i.
module sl_ifetch_prefetch
    import sl_ifetch_pkg::*;
#(
    parameter int PF_EN     = 1,
    parameter int PAGE_BITS = 12,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_val,
    input  logic [31:0]      i_req_addr,
    output logic             i_req_ack,
    output logic [31:0]      i_ack_rdata,
    output logic             c_req_val,
    output logic [31:0]      c_req_addr,
    input  logic             c_req_ack,
    input  logic [31:0]      c_ack_rdata,
    input  logic             pf_flush,
    output logic [CNT_W-1:0] stat_hit,
    output logic [CNT_W-1:0] stat_miss
);

    ifpf_state_t state, state_n;
    logic        buf_val, buf_val_n;
    waddr_t      buf_addr, buf_addr_n;
    logic [31:0] buf_data, buf_data_n;
    waddr_t      pf_addr, pf_addr_n;
    logic        drop, drop_n;

    logic        hit_inc, miss_inc;
    logic        launch;
    waddr_t      launch_src;

    waddr_t req_word;
    logic   buf_hit, pf_fwd;
    logic   unused_addr_lsb;

    assign req_word        = i_req_addr[31:2];
    assign unused_addr_lsb = ^i_req_addr[1:0];

    // Flush beats a same-cycle match, so the request falls back to a normal miss.
    assign buf_hit = i_req_val & buf_val & ~pf_flush & (req_word == buf_addr);
    assign pf_fwd  = i_req_val & ~drop & ~pf_flush & (req_word == pf_addr);

    // NOTE: every comb output and next-state gets a default first so no latch is inferred.
    always_comb begin
        state_n     = state;
        buf_val_n   = buf_val;
        buf_addr_n  = buf_addr;
        buf_data_n  = buf_data;
        pf_addr_n   = pf_addr;
        drop_n      = drop;
        launch      = 1'b0;
        launch_src  = req_word;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        i_req_ack   = 1'b0;
        i_ack_rdata = '0;
        c_req_val   = 1'b0;
        c_req_addr  = '0;

        if (PF_EN == 0) begin
            c_req_val   = i_req_val;
            c_req_addr  = {req_word, 2'b00};
            i_req_ack   = c_req_ack & i_req_val;
            i_ack_rdata = c_ack_rdata;
            miss_inc    = c_req_ack & i_req_val;
        end else begin
            if (pf_flush)
                buf_val_n = 1'b0;

            unique case (state)
                IDLE: begin
                    if (buf_hit) begin
                        i_req_ack   = 1'b1;
                        i_ack_rdata = buf_data;
                        buf_val_n   = 1'b0;
                        hit_inc     = 1'b1;
                        launch      = 1'b1;
                        launch_src  = buf_addr;
                    end else if (i_req_val) begin
                        state_n = FWD;
                    end
                end
                FWD: begin
                    c_req_val   = 1'b1;
                    c_req_addr  = {req_word, 2'b00};
                    i_req_ack   = c_req_ack & i_req_val;
                    i_ack_rdata = c_ack_rdata;
                    if (c_req_ack) begin
                        miss_inc   = 1'b1;
                        launch     = 1'b1;
                        launch_src = req_word;
                    end
                end
                PF: begin
                    c_req_val  = 1'b1;
                    c_req_addr = {pf_addr, 2'b00};
                    if (c_req_ack) begin
                        if (pf_fwd) begin
                            i_req_ack   = 1'b1;
                            i_ack_rdata = c_ack_rdata;
                            hit_inc     = 1'b1;
                            launch      = 1'b1;
                            launch_src  = pf_addr;
                        end else begin
                            if (!drop && !pf_flush) begin
                                buf_val_n  = 1'b1;
                                buf_addr_n = pf_addr;
                                buf_data_n = c_ack_rdata;
                            end
                            drop_n  = 1'b0;
                            state_n = IDLE;
                        end
                    end else if (pf_flush) begin
                        // The l1i handshake cannot be withdrawn; discard its data instead.
                        drop_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase

            if (launch) begin
                if (page_end(launch_src, PAGE_BITS)) begin
                    state_n = IDLE;
                end else begin
                    state_n   = PF;
                    pf_addr_n = next_word(launch_src);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            buf_val  <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            pf_addr  <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            buf_val  <= buf_val_n;
            buf_addr <= buf_addr_n;
            buf_data <= buf_data_n;
            pf_addr  <= pf_addr_n;
            drop     <= drop_n;
        end
    end

    sl_sat_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_inc),
        .clr (1'b0),
        .cnt (stat_hit)
    );

    sl_sat_cnt #(.W(CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (miss_inc),
        .clr (1'b0),
        .cnt (stat_miss)
    );

endmodule

// File: tb/tb_sl_ifetch_prefetch.sv
// Scoreboard bench for sl_ifetch_prefetch: l1i model with fixed latency,
// expected fetch data queued at request time and compared on i_req_ack.
module tb_sl_ifetch_prefetch;

    localparam int CW     = 4;
    localparam int L1_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_val;
    logic [31:0]   i_req_addr;
    logic          i_req_ack;
    logic [31:0]   i_ack_rdata;
    logic          c_req_val;
    logic [31:0]   c_req_addr;
    logic          c_req_ack;
    logic [31:0]   c_ack_rdata;
    logic          pf_flush;
    logic [CW-1:0] stat_hit;
    logic [CW-1:0] stat_miss;

    logic          pt_i_req_val;
    logic [31:0]   pt_i_req_addr;
    logic          pt_i_req_ack;
    logic [31:0]   pt_i_ack_rdata;
    logic          pt_c_req_val;
    logic [31:0]   pt_c_req_addr;
    logic          pt_c_req_ack;
    logic [31:0]   pt_c_ack_rdata;
    logic [CW-1:0] pt_stat_hit;
    logic [CW-1:0] pt_stat_miss;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   l1_log[$];
    bit            poison = 1'b0;
    int            wait_cnt = 0;

    always #5 clk = ~clk;

    sl_ifetch_prefetch #(.PF_EN(1), .PAGE_BITS(12), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_req_val(i_req_val), .i_req_addr(i_req_addr),
        .i_req_ack(i_req_ack), .i_ack_rdata(i_ack_rdata),
        .c_req_val(c_req_val), .c_req_addr(c_req_addr),
        .c_req_ack(c_req_ack), .c_ack_rdata(c_ack_rdata),
        .pf_flush(pf_flush),
        .stat_hit(stat_hit), .stat_miss(stat_miss)
    );

    sl_ifetch_prefetch #(.PF_EN(0), .PAGE_BITS(12), .CNT_W(CW)) dut_pt (
        .clk(clk), .rst(rst),
        .i_req_val(pt_i_req_val), .i_req_addr(pt_i_req_addr),
        .i_req_ack(pt_i_req_ack), .i_ack_rdata(pt_i_ack_rdata),
        .c_req_val(pt_c_req_val), .c_req_addr(pt_c_req_addr),
        .c_req_ack(pt_c_req_ack), .c_ack_rdata(pt_c_ack_rdata),
        .pf_flush(1'b0),
        .stat_hit(pt_stat_hit), .stat_miss(pt_stat_miss)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:2], 2'b11, ~a[15:0]};
    endfunction

    // l1i model: acks after L1_LAT wait cycles of a held request.
    initial begin
        c_req_ack   = 1'b0;
        c_ack_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            c_req_ack   = c_req_val && (wait_cnt >= L1_LAT);
            c_ack_rdata = c_req_ack ? (poison ? 32'hDEADBEEF : mem_word(c_req_addr)) : 32'h0;
            @(negedge clk);
            if (rst) l1_log.delete();
            else if (c_req_val && c_req_ack) l1_log.push_back(c_req_addr);
            if (rst || !c_req_val || c_req_ack) wait_cnt = 0;
            else wait_cnt++;
        end
    end

    task automatic monitor();
        logic        stab_pend = 1'b0;
        logic [31:0] stab_addr = '0;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                stab_pend = 1'b0;
            end else begin
                if (i_req_ack) begin
                    checks++;
                    if (!i_req_val) begin
                        errors++; $display("FAIL ack_without_req addr=%h", i_req_addr);
                    end else if (exp_q.size() == 0) begin
                        errors++; $display("FAIL unexpected_ack addr=%h got=%h", i_req_addr, i_ack_rdata);
                    end else begin
                        exp = exp_q.pop_front();
                        if (i_ack_rdata !== exp) begin
                            errors++; $display("FAIL rdata addr=%h got=%h exp=%h", i_req_addr, i_ack_rdata, exp);
                        end
                    end
                end
                if (stab_pend && c_req_val) begin
                    checks++;
                    if (c_req_addr !== stab_addr) begin
                        errors++; $display("FAIL c_addr_stable got=%h exp=%h", c_req_addr, stab_addr);
                    end
                end
                stab_pend = c_req_val && !c_req_ack;
                stab_addr = c_req_addr;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic fetch(input logic [31:0] a, output int lat_o);
        int cyc = 0;
        bit done = 1'b0;
        i_req_val  = 1'b1;
        i_req_addr = a;
        exp_q.push_back(mem_word(a));
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (i_req_ack) done = 1'b1;
            else begin step(); cyc++; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL fetch_timeout addr=%h got=no_ack exp=ack", a);
        end
        step();
        i_req_val = 1'b0;
        lat_o     = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_req_val = 1'b0; i_req_addr = '0; pf_flush = 1'b0; poison = 1'b0;
        pt_i_req_val = 1'b0; pt_i_req_addr = '0; pt_c_req_ack = 1'b0; pt_c_ack_rdata = '0;
        idle(2);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (c_req_val !== 1'b0) begin errors++; $display("FAIL rst_c_req_val got=%b exp=0", c_req_val); end
        checks++; if (i_req_ack !== 1'b0) begin errors++; $display("FAIL rst_i_req_ack got=%b exp=0", i_req_ack); end
        checks++; if (stat_hit !== '0) begin errors++; $display("FAIL rst_stat_hit got=%0d exp=0", stat_hit); end
        checks++; if (stat_miss !== '0) begin errors++; $display("FAIL rst_stat_miss got=%0d exp=0", stat_miss); end
        step();
    endtask

    task automatic test_sequential();
        int l;
        do_reset();
        fetch(32'h100, l);
        checks++; if (l != 3) begin errors++; $display("FAIL seq_lat_100 got=%0d exp=3", l); end
        idle(4);
        fetch(32'h104, l);
        checks++; if (l != 0) begin errors++; $display("FAIL seq_lat_104 got=%0d exp=0", l); end
        idle(4);
        fetch(32'h108, l);
        checks++; if (l != 0) begin errors++; $display("FAIL seq_lat_108 got=%0d exp=0", l); end
        checks++; if (stat_hit !== 4'd2) begin errors++; $display("FAIL seq_stat_hit got=%0d exp=2", stat_hit); end
        checks++; if (stat_miss !== 4'd1) begin errors++; $display("FAIL seq_stat_miss got=%0d exp=1", stat_miss); end
    endtask

    task automatic test_branch();
        int l;
        do_reset();
        fetch(32'h100, l);
        idle(4);
        fetch(32'h200, l);
        checks++; if (l != 3) begin errors++; $display("FAIL br_lat got=%0d exp=3", l); end
        idle(4);
        checks++;
        if (l1_log.size() < 4) begin
            errors++; $display("FAIL br_l1_count got=%0d exp=4", l1_log.size());
        end else begin
            if (l1_log[2] !== 32'h200) begin errors++; $display("FAIL br_fwd_addr got=%h exp=%h", l1_log[2], 32'h200); end
            checks++;
            if (l1_log[3] !== 32'h204) begin errors++; $display("FAIL br_pf_addr got=%h exp=%h", l1_log[3], 32'h204); end
        end
        checks++; if (stat_miss !== 4'd2) begin errors++; $display("FAIL br_stat_miss got=%0d exp=2", stat_miss); end
    endtask

    task automatic test_page_boundary();
        int l;
        int seen = 0;
        do_reset();
        fetch(32'hFFC, l);
        repeat (4) begin
            @(negedge clk);
            if (c_req_val) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL page_no_pf got=%0d exp=0", seen); end
        fetch(32'h1000, l);
        checks++; if (l != 3) begin errors++; $display("FAIL page_next_lat got=%0d exp=3", l); end
        checks++; if (stat_miss !== 4'd2) begin errors++; $display("FAIL page_stat_miss got=%0d exp=2", stat_miss); end
    endtask

    task automatic test_flush();
        int l;
        do_reset();
        fetch(32'h100, l);
        poison   = 1'b1;
        pf_flush = 1'b1;
        step();
        pf_flush = 1'b0;
        idle(3);
        poison = 1'b0;
        fetch(32'h104, l);
        checks++; if (l != 3) begin errors++; $display("FAIL flush_lat got=%0d exp=3", l); end
        checks++; if (stat_hit !== 4'd0) begin errors++; $display("FAIL flush_stat_hit got=%0d exp=0", stat_hit); end
        checks++; if (stat_miss !== 4'd2) begin errors++; $display("FAIL flush_stat_miss got=%0d exp=2", stat_miss); end
    endtask

    task automatic test_same_cycle();
        int l;
        do_reset();
        fetch(32'h100, l);
        fetch(32'h104, l);
        checks++; if (l != 2) begin errors++; $display("FAIL same_lat got=%0d exp=2", l); end
        @(negedge clk);
        checks++; if (c_req_val !== 1'b1) begin errors++; $display("FAIL same_next_val got=%b exp=1", c_req_val); end
        checks++; if (c_req_addr !== 32'h108) begin errors++; $display("FAIL same_next_addr got=%h exp=%h", c_req_addr, 32'h108); end
        checks++; if (stat_hit !== 4'd1) begin errors++; $display("FAIL same_stat_hit got=%0d exp=1", stat_hit); end
        step();
    endtask

    task automatic test_reset_fwd();
        int l;
        do_reset();
        fetch(32'h100, l);
        idle(4);
        i_req_val  = 1'b1;
        i_req_addr = 32'h300;
        step();
        @(negedge clk);
        checks++; if (c_req_addr !== 32'h300) begin errors++; $display("FAIL rfwd_addr got=%h exp=%h", c_req_addr, 32'h300); end
        step();
        rst = 1'b1;
        i_req_val = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (c_req_val !== 1'b0) begin errors++; $display("FAIL rfwd_c_req_val got=%b exp=0", c_req_val); end
        checks++; if (i_req_ack !== 1'b0) begin errors++; $display("FAIL rfwd_i_req_ack got=%b exp=0", i_req_ack); end
        checks++; if (stat_miss !== '0) begin errors++; $display("FAIL rfwd_stat_miss got=%0d exp=0", stat_miss); end
        step();
        fetch(32'h104, l);
        checks++; if (l != 3) begin errors++; $display("FAIL rfwd_buf_cleared got=%0d exp=3", l); end
    endtask

    task automatic test_saturation();
        int l;
        int bad = 0;
        do_reset();
        fetch(32'h100, l);
        idle(4);
        for (int i = 0; i < 20; i++) begin
            fetch(32'h104 + 32'(4 * i), l);
            if (l != 0) bad++;
            idle(4);
            if (i == 13) begin
                checks++; if (stat_hit !== 4'd14) begin errors++; $display("FAIL sat_mid got=%0d exp=14", stat_hit); end
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_hits got=%0d exp=0 slow fetches", bad); end
        checks++; if (stat_hit !== 4'd15) begin errors++; $display("FAIL sat_stat_hit got=%0d exp=15", stat_hit); end
        checks++; if (stat_miss !== 4'd1) begin errors++; $display("FAIL sat_stat_miss got=%0d exp=1", stat_miss); end
    endtask

    task automatic test_passthrough();
        do_reset();
        pt_i_req_val  = 1'b1;
        pt_i_req_addr = 32'h120;
        #1;
        checks++; if (pt_c_req_val !== 1'b1) begin errors++; $display("FAIL pt_c_req_val got=%b exp=1", pt_c_req_val); end
        checks++; if (pt_c_req_addr !== 32'h120) begin errors++; $display("FAIL pt_c_req_addr got=%h exp=%h", pt_c_req_addr, 32'h120); end
        checks++; if (pt_i_req_ack !== 1'b0) begin errors++; $display("FAIL pt_early_ack got=%b exp=0", pt_i_req_ack); end
        pt_c_req_ack   = 1'b1;
        pt_c_ack_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (pt_i_req_ack !== 1'b1) begin errors++; $display("FAIL pt_ack got=%b exp=1", pt_i_req_ack); end
        checks++; if (pt_i_ack_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL pt_rdata got=%h exp=%h", pt_i_ack_rdata, 32'hCAFEF00D); end
        step();
        pt_i_req_val = 1'b0;
        pt_c_req_ack = 1'b0;
        checks++; if (pt_stat_miss !== 4'd1) begin errors++; $display("FAIL pt_stat_miss got=%0d exp=1", pt_stat_miss); end
        checks++; if (pt_stat_hit !== 4'd0) begin errors++; $display("FAIL pt_stat_hit got=%0d exp=0", pt_stat_hit); end
    endtask

    initial begin
        rst = 1'b1; i_req_val = 1'b0; i_req_addr = '0; pf_flush = 1'b0;
        pt_i_req_val = 1'b0; pt_i_req_addr = '0; pt_c_req_ack = 1'b0; pt_c_ack_rdata = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_sequential();
        test_branch();
        test_page_boundary();
        test_flush();
        test_same_cycle();
        test_reset_fwd();
        test_saturation();
        test_passthrough();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sl_ifetch_prefetch.md
Name: sl_ifetch_prefetch

Overview:
Single-entry sequential instruction prefetcher between the core instruction fetch port and the L1 instruction cache (l1i). After each core fetch it speculatively fetches the next word (addr+4) from l1i and holds it. A matching next core fetch is then acknowledged from the buffer with zero wait. Otherwise requests pass through to l1i unchanged.

Parameters:
PF_EN, 1, 1 = prefetch enabled; 0 = pure combinational pass-through, buffer and FSM held idle
PAGE_BITS, 12, no prefetch across a 2^PAGE_BITS-byte boundary
CNT_W, 16, width of saturating statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_req_val  in  1  core fetch request, held until i_req_ack
i_req_addr  in  32  core fetch byte address; bits [1:0] ignored
i_req_ack  out  1  one-cycle accept; i_ack_rdata valid in the same cycle
i_ack_rdata  out  32  instruction word
c_req_val  out  1  request to l1i, held until c_req_ack
c_req_addr  out  32  l1i address, word aligned, stable while c_req_val
c_req_ack  in  1  l1i accept; c_ack_rdata valid in the same cycle
c_ack_rdata  in  32  l1i data
pf_flush  in  1  invalidate buffer (fence.i / l1i invalidate)
stat_hit  out  CNT_W  buffer hits, saturating
stat_miss  out  CNT_W  core requests served by l1i, saturating

Behaviour:
- Clock and reset: clk, synchronous active-high rst. The reset value of every output, counter and register is 0; FSM goes to IDLE; buf_val=0. Reset mid-transaction abandons any l1i request (l1i is reset with the block).
- State: buf_val, buf_addr[31:2], buf_data[31:0], pf_addr[31:2], drop flag.
- Address compare uses [31:2] only.
- IDLE state:
  - hit = i_req_val & buf_val & ~pf_flush & (i_req_addr[31:2]==buf_addr).
  - On a hit: i_req_ack=1 and i_ack_rdata=buf_data combinationally, in the same cycle. Clear buf_val, stat_hit++. Launch a prefetch of buf_addr+1; go to PF.
  - On a miss with i_req_val: go to FWD the next cycle.
  - i_req_ack is 0 in the cycle the miss is detected, so the minimum miss latency is 1 cycle plus l1i latency.
- FWD state:
  - c_req_val=1, c_req_addr={i_req_addr[31:2],2'b00}.
  - i_req_ack=c_req_ack and i_ack_rdata=c_ack_rdata, passed through.
  - On c_req_ack: stat_miss++, then launch a prefetch of addr+1 and go to PF.
- PF state:
  - c_req_val=1, c_req_addr={pf_addr,2'b00}, held until c_req_ack.
  - Core request to pf_addr in the same cycle as c_req_ack (and no drop): forward c_ack_rdata to the core with i_req_ack=1 and count a hit. Do not fill the buffer; launch a prefetch of pf_addr+1 and stay in PF.
  - Otherwise, on c_req_ack: fill the buffer (buf_val=1, buf_addr=pf_addr, buf_data=c_ack_rdata) unless drop is set; clear drop; go to IDLE.
  - A core request arriving while a prefetch is outstanding waits with i_req_ack=0 until the FSM returns to IDLE, then is evaluated as hit or miss.
- Prefetch launch rule: if addr[PAGE_BITS-1:2] is all ones (page end, which includes the 0xFFFFFFFC wrap), suppress the prefetch and go to IDLE. Address arithmetic is mod 2^32.
- pf_flush:
  - Clears buf_val the same cycle.
  - In PF, sets drop: the outstanding l1i request still completes (the l1i handshake is never withdrawn) and its data is discarded.
  - Flush wins over a simultaneous hit; that core request is then treated as a miss.
- Invariants:
  - At most one l1i request is outstanding.
  - c_req_addr never changes while c_req_val=1 and c_req_ack=0.
  - i_req_ack is never asserted without i_req_val.
- Counters stop at 2^CNT_W-1.
- With PF_EN=0: c_req_*=i_req_*, i_ack_*=c_ack_*, stat_miss counts acks, stat_hit stays 0.

Decomposition:
- Package sl_ifetch_pkg:
  - typedef enum {IDLE, FWD, PF} ifpf_state_t.
  - typedef word address logic[29:0].
  - Function next_word(addr).
  - Function page_end(addr, PAGE_BITS).
- Sub-module sl_sat_cnt (parameter W; inc, clr), instantiated twice for stat_hit and stat_miss.

Test Plan:
- Sequential fetch of 0x100, 0x104, 0x108 with l1i latency 2: 0x100 acks at cycle 3 (miss). Prefetch of 0x104 completes before the core request, so 0x104 and 0x108 ack in their request cycle. stat_hit=2, stat_miss=1.
- Branch: after 0x100, the core requests 0x200 while the buffer holds 0x104 → miss via FWD with c_req_addr=0x200, then prefetch of 0x204. stat_miss=2.
- Page boundary: fetch 0xFFC → no c_req_val in the following cycles. Next fetch 0x1000 is a miss.
- Flush during PF: prefetch of 0x104 outstanding, pf_flush pulsed, l1i acks 0xDEADBEEF → buf_val stays 0. Request 0x104 is a miss that fetches from l1i again.
- Core request to 0x104 arriving in the same cycle as the l1i prefetch ack → i_req_ack=1 with rdata=c_ack_rdata. Next c_req_addr=0x108.
- Reset asserted during FWD → next cycle c_req_val=0, i_req_ack=0, stats 0. Counter saturation with CNT_W=4: 20 hits → stat_hit=15.
